// File: rtl/button_pkg.sv
// button_pkg: constants and types shared by the button conditioner files.
//   CLK_HZ            nominal system clock (3.6864 MHz)
//   DEBOUNCE_CYC      stable cycles needed to accept a level change (5 ms)
//   REPEAT_DELAY_CYC  cycles from the first press pulse to the first repeat (500 ms)
//   REPEAT_RATE_CYC   cycles between later repeat pulses (100 ms)
//   rep_state_t       per-channel auto-repeat FSM state
package button_pkg;

  localparam int unsigned CLK_HZ           = 3686400;
  localparam int unsigned DEBOUNCE_CYC     = 18432;
  localparam int unsigned REPEAT_DELAY_CYC = 1843200;
  localparam int unsigned REPEAT_RATE_CYC  = 368640;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: pin and pulse bundle of the button conditioner.
//   button_A/B  raw asynchronous pins (pin side drives them)
//   level_a/b   debounced pressed state, 1 = pressed
//   press_a/b   one-cycle strobe on a press or an auto-repeat
//   chord       one-cycle strobe when both levels become 1
//   state_a/b   repeat-FSM state of each channel, for observation only
//
// Strobe semantics: there is no valid/ready handshake. Every press/chord
// strobe is high for exactly one clk cycle and is never held off or
// retried; the consumer must sample it on every clock edge. Levels are
// plain registered signals that may be sampled at any time.
interface button_conditioner_if;

  logic                   button_A;
  logic                   button_B;
  logic                   level_a;
  logic                   level_b;
  logic                   press_a;
  logic                   press_b;
  logic                   chord;
  button_pkg::rep_state_t state_a;
  button_pkg::rep_state_t state_b;

  // pin / consumer side
  modport master (
    output button_A, button_B,
    input  level_a, level_b, press_a, press_b, chord, state_a, state_b
  );

  // conditioner side
  modport slave (
    input  button_A, button_B,
    output level_a, level_b, press_a, press_b, chord, state_a, state_b
  );

endinterface

// File: rtl/button_channel.sv
// button_channel: one button: 2-flop synchroniser, debounce counter and
// auto-repeat FSM.
//   clk, rst    system clock, asynchronous active-high reset
//   pin_i       raw asynchronous pin
//   hold_i      freeze the repeat counter (both buttons held)
//   level_o     registered debounced level, 1 = pressed
//   level_d_o   next-cycle value of level_o (for chord detection upstream)
//   press_o     registered one-cycle press / repeat strobe
//   state_o     registered repeat-FSM state
module button_channel #(
  parameter int unsigned DEBOUNCE_CYC     = button_pkg::DEBOUNCE_CYC,
  parameter int unsigned REPEAT_DELAY_CYC = button_pkg::REPEAT_DELAY_CYC,
  parameter int unsigned REPEAT_RATE_CYC  = button_pkg::REPEAT_RATE_CYC,
  parameter bit          REPEAT_EN        = 1'b1,
  parameter bit          ACTIVE_LOW       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin_i,
  input  logic       hold_i,
  output logic       level_o,
  output logic       level_d_o,
  output logic       press_o,
  output button_pkg::rep_state_t state_o
);

  import button_pkg::*;

  localparam int unsigned REP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                    REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned RW = $clog2(REP_MAX + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE_CYC - 1);
  // Released pin value: synchroniser resets here so reset release is quiet.
  localparam logic          PIN_IDLE  = ACTIVE_LOW;

  logic          sync1_q, sync2_q;
  logic          s2;
  logic          level_q, level_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  rep_state_t    state_q, state_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          press_q, press_d;
  logic          rise, fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= PIN_IDLE;
      sync2_q <= PIN_IDLE;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  assign s2 = sync2_q ^ ACTIVE_LOW;

  // Debounce: count consecutive disagreeing cycles; any agreement clears.
  always_comb begin
    level_d   = level_q;
    deb_cnt_d = '0;
    if (s2 != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        level_d = ~level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = level_q & ~level_d;

  // Repeat FSM. Decisions use level_d so the first press strobe lands in
  // the same cycle the registered level goes high.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    press_d   = 1'b0;
    if (fall) begin
      state_d   = ST_IDLE;
      rep_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d   = ST_DELAY;
            rep_cnt_d = '0;
            press_d   = 1'b1;
          end
        end
        ST_DELAY: begin
          // Without auto-repeat DELAY simply waits for release.
          if (REPEAT_EN && !hold_i) begin
            if (rep_cnt_q == DLY_LAST) begin
              state_d   = ST_REPEAT;
              rep_cnt_d = '0;
              press_d   = 1'b1;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
        end
        ST_REPEAT: begin
          if (!hold_i) begin
            if (rep_cnt_q == RATE_LAST) begin
              rep_cnt_d = '0;
              press_d   = 1'b1;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d   = ST_IDLE;
          rep_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= 1'b0;
      deb_cnt_q <= '0;
      state_q   <= ST_IDLE;
      rep_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      level_q   <= level_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      press_q   <= press_d;
    end
  end

  assign level_o   = level_q;
  assign level_d_o = level_d;
  assign press_o   = press_q;
  assign state_o   = state_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: conditions the two push-button pins into debounced
// levels, press/auto-repeat strobes and a chord strobe.
//   clk, rst  system clock (3.6864 MHz), asynchronous active-high reset
//   btn_if    button_conditioner_if.slave: pins in; levels, strobes,
//             chord and FSM states out
// Holds only the chord detect and the repeat-suppress gating; each button
// is handled by a button_channel.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYC     = button_pkg::DEBOUNCE_CYC,
  parameter int unsigned REPEAT_DELAY_CYC = button_pkg::REPEAT_DELAY_CYC,
  parameter int unsigned REPEAT_RATE_CYC  = button_pkg::REPEAT_RATE_CYC,
  parameter bit          REPEAT_EN        = 1'b1,
  parameter bit          ACTIVE_LOW       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  button_conditioner_if.slave btn_if
);

  import button_pkg::*;

  logic       level_a, level_b;
  logic       level_a_d, level_b_d;
  logic       press_a, press_b;
  rep_state_t state_a, state_b;
  logic       hold;
  logic       chord_q, chord_d;

  // Repeat counters freeze while both debounced levels are high.
  assign hold = level_a & level_b;

  button_channel #(
    .DEBOUNCE_CYC    (DEBOUNCE_CYC),
    .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
    .REPEAT_RATE_CYC (REPEAT_RATE_CYC),
    .REPEAT_EN       (REPEAT_EN),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_chan_a (
    .clk      (clk),
    .rst      (rst),
    .pin_i    (btn_if.button_A),
    .hold_i   (hold),
    .level_o  (level_a),
    .level_d_o(level_a_d),
    .press_o  (press_a),
    .state_o  (state_a)
  );

  button_channel #(
    .DEBOUNCE_CYC    (DEBOUNCE_CYC),
    .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
    .REPEAT_RATE_CYC (REPEAT_RATE_CYC),
    .REPEAT_EN       (REPEAT_EN),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_chan_b (
    .clk      (clk),
    .rst      (rst),
    .pin_i    (btn_if.button_B),
    .hold_i   (hold),
    .level_o  (level_b),
    .level_d_o(level_b_d),
    .press_o  (press_b),
    .state_o  (state_b)
  );

  // Chord fires on the edge where the AND of the levels rises, aligned
  // with the registered levels (and with both press strobes when the two
  // levels rise together).
  assign chord_d = (level_a_d & level_b_d) & ~(level_a & level_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chord_q <= 1'b0;
    end else begin
      chord_q <= chord_d;
    end
  end

  assign btn_if.level_a = level_a;
  assign btn_if.level_b = level_b;
  assign btn_if.press_a = press_a;
  assign btn_if.press_b = press_b;
  assign btn_if.chord   = chord_q;
  assign btn_if.state_a = state_a;
  assign btn_if.state_b = state_b;

endmodule
